// File: rtl/instruction_fetch.sv
// Instruction fetch controller: issues one memory read per instruction, hands the
// word to decode with a valid/ready handshake and drains requests overtaken by a flush.
module instruction_fetch (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic        pc_en,
  input  logic        flush,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic          load_instr;

  // State register
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch address and instruction holding registers
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      addr_q   <= '0;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      if (state == REQ) begin
        addr_q <= pc;
      end
      if (load_instr) begin
        instr    <= DW'(imem_rdata);
        instr_pc <= AW'(pc);
      end
    end
  end

  // Next state and handshake outputs; a flush always advances the program counter
  always_comb begin
    state_nxt   = state;
    pc_en       = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = '0;
    instr_valid = 1'b0;
    load_instr  = 1'b0;

    case (state)
      IDLE: begin
        state_nxt = REQ;
        pc_en     = flush;
      end
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (flush) begin
          pc_en     = 1'b1;
          state_nxt = imem_ack ? REQ : DRAIN;
        end else if (imem_ack) begin
          pc_en      = 1'b1;
          load_instr = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (flush) begin
          pc_en     = 1'b1;
          state_nxt = REQ;
        end else if (instr_ready) begin
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        // Request already issued at addr_q must complete; its data is dropped
        imem_req  = 1'b1;
        imem_addr = addr_q;
        pc_en     = flush;
        if (imem_ack) begin
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Reset abandons any outstanding request at once
    if (reset) begin
      pc_en       = 1'b0;
      imem_req    = 1'b0;
      imem_addr   = '0;
      instr_valid = 1'b0;
      load_instr  = 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle table followed by randomized traffic
// against a transaction-level model of fetch, delivery and flush behaviour.
module tb_instruction_fetch;

  logic        sys_clock;
  logic        reset;
  logic [15:0] pc;
  logic        pc_en;
  logic        flush;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  int tests = 0;
  int fails = 0;

  instruction_fetch dut (
    .sys_clock  (sys_clock),
    .reset      (reset),
    .pc         (pc),
    .pc_en      (pc_en),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        flush;
    logic        ack;
    logic [15:0] rdata;
    logic        ready;
    logic        e_en;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_ipc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [15:0] p, logic fl, logic ak, logic [15:0] rd,
                              logic rdy, logic en, logic rq, logic [15:0] ad, logic vl,
                              logic [15:0] ins, logic [15:0] ipc);
    vec_t v;
    v.rst = rst; v.pc = p; v.flush = fl; v.ack = ak; v.rdata = rd; v.ready = rdy;
    v.e_en = en; v.e_req = rq; v.e_addr = ad; v.e_valid = vl; v.e_instr = ins; v.e_ipc = ipc;
    return v;
  endfunction

  // Contents of the bench's instruction memory
  function automatic logic [15:0] memf(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Random-phase model state
  logic        m_hold;
  logic        m_idle;
  logic        m_stale;
  logic [15:0] m_stale_addr;
  logic [15:0] m_hold_pc;
  logic [15:0] m_hold_data;
  logic [15:0] pc_next;
  logic [15:0] target;
  logic        mem_active;
  int          mem_wait;
  logic        e_en;
  logic        e_req;
  logic [15:0] e_addr;
  logic        delivered;

  initial begin
    reset = 1'b1; pc = '0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    repeat (2) @(posedge sys_clock);

    //            rst pc       fl ak rdata     rdy  en rq addr     vl instr     ipc
    vecs.push_back(mk(1, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 16'hA5A5, 0,  1, 1, 16'h0000, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h0001, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'hA5A5, 16'h0000));
    vecs.push_back(mk(0, 16'h0001, 0, 0, 16'h0000, 1,  0, 0, 16'h0000, 1, 16'hA5A5, 16'h0000));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 16'h0010, 0, 0, 16'h0000, 0, 0, 1, 16'h0010, 0, 16'hA5A5, 16'h0000));
    vecs.push_back(mk(0, 16'h0010, 0, 1, 16'h1234, 0,  1, 1, 16'h0010, 0, 16'hA5A5, 16'h0000));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 16'h0011, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h1234, 16'h0010));
    vecs.push_back(mk(0, 16'h0011, 0, 0, 16'h0000, 1,  0, 0, 16'h0000, 1, 16'h1234, 16'h0010));
    vecs.push_back(mk(0, 16'h0020, 0, 0, 16'h0000, 0,  0, 1, 16'h0020, 0, 16'h1234, 16'h0010));
    vecs.push_back(mk(0, 16'h0020, 1, 0, 16'h0000, 0,  1, 1, 16'h0020, 0, 16'h1234, 16'h0010));
    vecs.push_back(mk(0, 16'h0100, 0, 0, 16'h0000, 0,  0, 1, 16'h0020, 0, 16'h1234, 16'h0010));
    vecs.push_back(mk(0, 16'h0100, 0, 1, 16'hDEAD, 0,  0, 1, 16'h0020, 0, 16'h1234, 16'h0010));
    vecs.push_back(mk(0, 16'h0100, 0, 1, 16'hBEEF, 0,  1, 1, 16'h0100, 0, 16'h1234, 16'h0010));
    vecs.push_back(mk(0, 16'h0101, 1, 0, 16'h0000, 1,  1, 0, 16'h0000, 1, 16'hBEEF, 16'h0100));
    vecs.push_back(mk(0, 16'h0200, 0, 0, 16'h0000, 0,  0, 1, 16'h0200, 0, 16'hBEEF, 16'h0100));
    vecs.push_back(mk(0, 16'h0200, 1, 0, 16'h0000, 0,  1, 1, 16'h0200, 0, 16'hBEEF, 16'h0100));
    vecs.push_back(mk(0, 16'h0300, 0, 0, 16'h0000, 0,  0, 1, 16'h0200, 0, 16'hBEEF, 16'h0100));
    vecs.push_back(mk(1, 16'h0300, 0, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 16'hBEEF, 16'h0100));
    vecs.push_back(mk(0, 16'h0300, 0, 1, 16'h7777, 0,  0, 0, 16'h0000, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h0300, 0, 0, 16'h0000, 0,  0, 1, 16'h0300, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h0300, 1, 1, 16'h5555, 0,  1, 1, 16'h0300, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 16'h0400, 0, 0, 16'h0000, 0,  0, 1, 16'h0400, 0, 16'h0000, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge sys_clock); #1;
      reset = vecs[i].rst; pc = vecs[i].pc; flush = vecs[i].flush;
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata; instr_ready = vecs[i].ready;
      @(negedge sys_clock);
      chk($sformatf("row%0d pc_en", i),       16'(pc_en),       16'(vecs[i].e_en));
      chk($sformatf("row%0d imem_req", i),    16'(imem_req),    16'(vecs[i].e_req));
      chk($sformatf("row%0d imem_addr", i),   imem_addr,        vecs[i].e_addr);
      chk($sformatf("row%0d instr_valid", i), 16'(instr_valid), 16'(vecs[i].e_valid));
      chk($sformatf("row%0d instr", i),       instr,            vecs[i].e_instr);
      chk($sformatf("row%0d instr_pc", i),    instr_pc,         vecs[i].e_ipc);
    end

    // Randomized traffic; the program counter and memory live in the bench
    @(posedge sys_clock); #1;
    reset = 1'b1; flush = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    @(posedge sys_clock); #1;
    m_hold = 1'b0; m_idle = 1'b1; m_stale = 1'b0; m_stale_addr = '0;
    m_hold_pc = '0; m_hold_data = '0; pc_next = '0; mem_active = 1'b0; mem_wait = 0;

    for (int c = 0; c < 4000; c++) begin
      if (c != 0) begin
        @(posedge sys_clock); #1;
      end
      pc    = pc_next;
      reset = (c != 0) && ($urandom_range(0, 99) < 2);
      #1;
      imem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
      if (reset) begin
        mem_active = 1'b0;
      end else if (imem_req) begin
        if (!mem_active) begin
          mem_active = 1'b1;
          mem_wait   = $urandom_range(0, 3);
        end
        if (mem_wait == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = memf(imem_addr);
          mem_active = 1'b0;
        end else begin
          mem_wait--;
        end
      end
      flush       = !reset && ($urandom_range(0, 99) < 10);
      target      = 16'($urandom);
      instr_ready = ($urandom_range(0, 99) < 60);
      @(negedge sys_clock);

      if (reset) begin
        chk("rst pc_en", 16'(pc_en), 16'h0);
        chk("rst imem_req", 16'(imem_req), 16'h0);
        chk("rst imem_addr", imem_addr, 16'h0);
        chk("rst instr_valid", 16'(instr_valid), 16'h0);
        m_hold = 1'b0; m_idle = 1'b1; m_stale = 1'b0; pc_next = '0;
      end else begin
        e_req  = !m_hold && !m_idle;
        e_addr = !e_req ? 16'h0 : (m_stale ? m_stale_addr : pc);
        e_en   = flush || (imem_ack && e_req && !m_stale);
        chk("rnd pc_en", 16'(pc_en), 16'(e_en));
        chk("rnd imem_req", 16'(imem_req), 16'(e_req));
        chk("rnd imem_addr", imem_addr, e_addr);
        chk("rnd instr_valid", 16'(instr_valid), 16'(m_hold));
        if (m_hold) begin
          chk("rnd instr", instr, m_hold_data);
          chk("rnd instr_pc", instr_pc, m_hold_pc);
        end
        delivered = imem_ack && e_req && !m_stale && !flush;
        if (flush || (m_hold && instr_ready)) m_hold = 1'b0;
        if (delivered) begin
          m_hold = 1'b1; m_hold_pc = pc; m_hold_data = memf(pc);
        end
        if (e_req && imem_ack) begin
          m_stale = 1'b0;
        end else if (flush && e_req && !m_stale) begin
          m_stale = 1'b1; m_stale_addr = pc;
        end
        m_idle  = 1'b0;
        pc_next = e_en ? (flush ? target : 16'(pc + 16'd1)) : pc;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
